// File: rtl/input_debounce_pkg.sv
// Shared board-input constants and types for the input debouncer.
package input_debounce_pkg;

    localparam int CLK_HZ          = 50_000_000;
    // 10 ms of stability at the board clock
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int NUM_BOARD_IN    = 12;

    localparam int BTN0_IDX   = 0;
    localparam int BTN1_IDX   = 1;
    localparam int SW_LSB_IDX = 2;

    // Buttons are wired active-low on the board; switches are active-high.
    localparam logic [NUM_BOARD_IN-1:0] DEFAULT_INVERT_MASK = 12'h003;

    // Per-bit debouncer result: clean level plus edge pulses.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } deb_out_t;

    // Stability counter width; must hold 0..STABLE_CYCLES-1 and never be zero-width.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_debounce_if.sv
// Raw pin bus in, debounced level and edge pulses out.
interface input_debounce_if
    import input_debounce_pkg::*;
#(
    parameter int NUM_IN = NUM_BOARD_IN
);
    logic [NUM_IN-1:0] RawIn;
    logic [NUM_IN-1:0] CleanOut;
    logic [NUM_IN-1:0] RisePulse;
    logic [NUM_IN-1:0] FallPulse;

    // Board side: drives pins, consumes clean signals
    modport master (
        output RawIn,
        input  CleanOut,
        input  RisePulse,
        input  FallPulse
    );

    // Debouncer side
    modport slave (
        input  RawIn,
        output CleanOut,
        output RisePulse,
        output FallPulse
    );
endinterface

// File: rtl/input_debounce_bit.sv
// Single-bit synchroniser, stability counter, clean level and edge-pulse flops.
module debounce_bit
    import input_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     din_i,
    output deb_out_t out_o
);
    localparam int             CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous pin level through the synchroniser chain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    // Count consecutive cycles of disagreement; accept the new level on the last one
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register counter, clean level and one-cycle edge pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out_o = '{level: level_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/input_debounce.sv
// Board-input debouncer: polarity fix-up, one debounce_bit per pin, bus packing.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int                NUM_IN        = NUM_BOARD_IN,
    parameter int                STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int                SYNC_STAGES   = 2,
    parameter logic [NUM_IN-1:0] INVERT_MASK   = NUM_IN'(DEFAULT_INVERT_MASK)
) (
    input  logic             Clock,
    input  logic             Rst,
    input_debounce_if.slave  bus
);
    logic [NUM_IN-1:0] pin_active;
    logic [NUM_IN-1:0] level_vec;
    logic [NUM_IN-1:0] rise_vec;
    logic [NUM_IN-1:0] fall_vec;

    // Active-low pins are flipped before synchronising so every bit is active-high inside
    assign pin_active = bus.RawIn ^ INVERT_MASK;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bit
        deb_out_t bit_out;

        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_bit (
            .clk_i (Clock),
            .rst_i (Rst),
            .din_i (pin_active[gi]),
            .out_o (bit_out)
        );

        assign level_vec[gi] = bit_out.level;
        assign rise_vec[gi]  = bit_out.rise;
        assign fall_vec[gi]  = bit_out.fall;
    end

    assign bus.CleanOut  = level_vec;
    assign bus.RisePulse = rise_vec;
    assign bus.FallPulse = fall_vec;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with STABLE_CYCLES=8, SYNC_STAGES=2.
module tb_input_debounce;

    logic Clock = 1'b0;
    logic Rst   = 1'b0;

    input_debounce_if #(.NUM_IN(12)) bus ();

    input_debounce #(
        .NUM_IN        (12),
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2),
        .INVERT_MASK   (12'h003)
    ) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int total_cnt = 0;
    int pass_cnt  = 0;

    int rise_cnt [12];
    int fall_cnt [12];
    int both_cnt = 0;

    initial begin
        for (int i = 0; i < 12; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    end

    // Pulse tally sampled mid-cycle
    always @(negedge Clock) begin
        for (int i = 0; i < 12; i++) begin
            if (bus.RisePulse[i] === 1'b1) rise_cnt[i]++;
            if (bus.FallPulse[i] === 1'b1) fall_cnt[i]++;
            if (bus.RisePulse[i] === 1'b1 && bus.FallPulse[i] === 1'b1) both_cnt++;
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [11:0] raw;
        int          n;
        logic [11:0] clean;
        logic [11:0] rise;
        logic [11:0] fall;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int  r0, f0;
        logic bounce_seen;

        vecs.push_back('{name:"idle",          raw:12'h003, n:20, clean:12'h000, rise:12'h000, fall:12'h000});
        vecs.push_back('{name:"press_pre",     raw:12'h002, n:9,  clean:12'h000, rise:12'h000, fall:12'h000});
        vecs.push_back('{name:"press_flip",    raw:12'h002, n:1,  clean:12'h001, rise:12'h001, fall:12'h000});
        vecs.push_back('{name:"press_hold",    raw:12'h002, n:1,  clean:12'h001, rise:12'h000, fall:12'h000});
        vecs.push_back('{name:"release_pre",   raw:12'h003, n:9,  clean:12'h001, rise:12'h000, fall:12'h000});
        vecs.push_back('{name:"release_flip",  raw:12'h003, n:1,  clean:12'h000, rise:12'h000, fall:12'h001});
        vecs.push_back('{name:"release_hold",  raw:12'h003, n:1,  clean:12'h000, rise:12'h000, fall:12'h000});
        vecs.push_back('{name:"indep_pre",     raw:12'hFFE, n:9,  clean:12'h000, rise:12'h000, fall:12'h000});
        vecs.push_back('{name:"indep_flip",    raw:12'hFFE, n:1,  clean:12'hFFD, rise:12'hFFD, fall:12'h000});
        vecs.push_back('{name:"indep_hold",    raw:12'hFFE, n:1,  clean:12'hFFD, rise:12'h000, fall:12'h000});
        vecs.push_back('{name:"indep_back",    raw:12'h003, n:10, clean:12'h000, rise:12'h000, fall:12'hFFD});
        vecs.push_back('{name:"indep_quiet",   raw:12'h003, n:1,  clean:12'h000, rise:12'h000, fall:12'h000});

        // Reset with buttons released
        bus.RawIn = 12'h003;
        #2;
        Rst = 1'b1;
        #1;
        chk("rst_clean", bus.CleanOut,  12'h000);
        chk("rst_rise",  bus.RisePulse, 12'h000);
        chk("rst_fall",  bus.FallPulse, 12'h000);
        edges(3);
        Rst = 1'b0;

        // Table-driven vectors
        for (int v = 0; v < vecs.size(); v++) begin
            bus.RawIn = vecs[v].raw;
            edges(vecs[v].n);
            chk({vecs[v].name, "_clean"}, bus.CleanOut,  vecs[v].clean);
            chk({vecs[v].name, "_rise"},  bus.RisePulse, vecs[v].rise);
            chk({vecs[v].name, "_fall"},  bus.FallPulse, vecs[v].fall);
        end

        // Bounce on switch 0 (bit 2): 3-cycle high/low phases never settle
        r0 = rise_cnt[2];
        bounce_seen = 1'b0;
        for (int p = 0; p < 7; p++) begin
            bus.RawIn[2] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                edges(1);
                if (bus.CleanOut[2] !== 1'b0) bounce_seen = 1'b1;
            end
            bus.RawIn[2] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                edges(1);
                if (bus.CleanOut[2] !== 1'b0) bounce_seen = 1'b1;
            end
        end
        chk("bounce_hold", {11'b0, bounce_seen}, 12'h000);
        bus.RawIn[2] = 1'b1;
        edges(9);
        chk("bounce_pre",  bus.CleanOut, 12'h000);
        edges(1);
        chk("bounce_flip", bus.CleanOut, 12'h004);
        edges(3);
        chk("bounce_rise_count", 12'(rise_cnt[2] - r0), 12'h001);
        bus.RawIn[2] = 1'b0;
        edges(12);
        chk("bounce_back", bus.CleanOut, 12'h000);

        // Near-miss on bit 3: seven synchronised high cycles only
        r0 = rise_cnt[3];
        f0 = fall_cnt[3];
        bounce_seen = 1'b0;
        bus.RawIn[3] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            edges(1);
            if (bus.CleanOut[3] !== 1'b0) bounce_seen = 1'b1;
        end
        bus.RawIn[3] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            edges(1);
            if (bus.CleanOut[3] !== 1'b0) bounce_seen = 1'b1;
        end
        chk("nearmiss_level",  {11'b0, bounce_seen}, 12'h000);
        chk("nearmiss_pulses", 12'(rise_cnt[3] - r0 + fall_cnt[3] - f0), 12'h000);

        // Reset while outputs are high, then re-debounce a held input
        bus.RawIn = 12'hFFE;
        edges(10);
        chk("held_flip", bus.CleanOut, 12'hFFD);
        #3;
        Rst = 1'b1;
        #1;
        chk("held_rst_clean", bus.CleanOut,  12'h000);
        chk("held_rst_rise",  bus.RisePulse, 12'h000);
        edges(1);
        Rst = 1'b0;
        edges(9);
        chk("held_redeb_pre",  bus.CleanOut, 12'h000);
        edges(1);
        chk("held_redeb_flip", bus.CleanOut, 12'hFFD);
        bus.RawIn = 12'h003;
        edges(12);
        chk("held_back", bus.CleanOut, 12'h000);

        // Reset mid-count on button 1
        r0 = rise_cnt[1];
        bus.RawIn = 12'h001;
        edges(5);
        Rst = 1'b1;
        #1;
        chk("midrst_clean", bus.CleanOut, 12'h000);
        edges(2);
        Rst = 1'b0;
        edges(9);
        chk("midrst_pre",        bus.CleanOut, 12'h000);
        chk("midrst_no_pulse",   12'(rise_cnt[1] - r0), 12'h000);
        edges(1);
        chk("midrst_flip_clean", bus.CleanOut,  12'h002);
        chk("midrst_flip_rise",  bus.RisePulse, 12'h002);
        bus.RawIn = 12'h003;
        edges(12);
        chk("midrst_back", bus.CleanOut, 12'h000);

        chk("never_both_pulses", 12'(both_cnt), 12'h000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
